// File: rtl/calc_accumulator_engine.sv
// Saturating signed accumulator with serial double-dabble BCD conversion of |acc|.
// Build option: CALC_LEADING_ZERO_BLANK_EN drives blank code 4'hF into leading-zero digits.
// state | meaning
// IDLE  | waiting for CMD_CLEAR / CMD_COMPUTE
// CALC  | apply latched command to the accumulator, load the shifter
// CONV  | one double-dabble step per cycle, MAG_W cycles
module calc_accumulator_engine #(
    parameter int DATA_WIDTH = 10,
    parameter int ACC_WIDTH  = 16,
    parameter int DIGITS     = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CMD_CLEAR,
    input  logic                    CMD_COMPUTE,
    input  logic                    CMD_OPERATION,
    input  logic [DATA_WIDTH-1:0]   OPERAND,
    output logic                    CMD_DONE,
    output logic                    BUSY,
    output logic [4*DIGITS-1:0]     RESULT_BCD,
    output logic                    RESULT_SIGN,
    output logic                    OVERFLOW
);

    localparam int MAG_W = ACC_WIDTH - 1;
    localparam int CNT_W = $clog2(MAG_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;

    localparam logic signed [ACC_WIDTH:0]   MAX_EXT = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0]   MIN_EXT = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0]        MAX_ACC = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]        MIN_ACC = {1'b1, {(ACC_WIDTH-2){1'b0}}, 1'b1};

    logic [1:0]              state_q;
    logic                    op_clear_q, op_sub_q;
    logic [DATA_WIDTH-1:0]   operand_q;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    ovf_pend_q, ovf_d;
    logic [MAG_W-1:0]        mag_q, mag_d;
    logic [4*DIGITS-1:0]     bcd_q, bcd_adj, bcd_d, result_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    done_q, busy_q, sign_q, ovf_q;
    logic [4*DIGITS-1:0]     result_bcd_q;
    logic signed [ACC_WIDTH:0] acc_ext, opnd_ext, sum_ext;

    always_comb begin
        acc_ext  = $signed({acc_q[ACC_WIDTH-1], acc_q});
        opnd_ext = $signed({{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, operand_q});
        sum_ext  = op_sub_q ? (acc_ext - opnd_ext) : (acc_ext + opnd_ext);
        acc_d    = sum_ext[ACC_WIDTH-1:0];
        ovf_d    = 1'b0;
        if (op_clear_q) begin
            acc_d = '0;
        end else if (sum_ext > MAX_EXT) begin
            acc_d = MAX_ACC;
            ovf_d = 1'b1;
        end else if (sum_ext < MIN_EXT) begin
            acc_d = MIN_ACC;
            ovf_d = 1'b1;
        end
        // Clamped range excludes the most-negative code, so the magnitude fits MAG_W bits
        mag_d = acc_d[ACC_WIDTH-1] ? MAG_W'(-acc_d) : acc_d[MAG_W-1:0];
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, mag_q[MAG_W-1]};
    end

`ifdef CALC_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic leading;
        result_d = bcd_d;
        leading  = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            if (leading && (bcd_d[4*i +: 4] == 4'd0)) result_d[4*i +: 4] = 4'hF;
            else                                      leading = 1'b0;
        end
    end
`else
    always_comb begin
        result_d = bcd_d;
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            op_clear_q   <= 1'b0;
            op_sub_q     <= 1'b0;
            operand_q    <= '0;
            acc_q        <= '0;
            ovf_pend_q   <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            result_bcd_q <= '0;
            sign_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CMD_CLEAR) begin
                        op_clear_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end else if (CMD_COMPUTE) begin
                        op_clear_q <= 1'b0;
                        op_sub_q   <= CMD_OPERATION;
                        operand_q  <= OPERAND;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q      <= acc_d;
                    ovf_pend_q <= ovf_d;
                    mag_q      <= mag_d;
                    bcd_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= S_CONV;
                end
                S_CONV: begin
                    mag_q <= mag_q << 1;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MAG_W-1)) begin
                        result_bcd_q <= result_d;
                        sign_q       <= acc_q[ACC_WIDTH-1];
                        ovf_q        <= ovf_pend_q;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CMD_DONE    = done_q;
    assign BUSY        = busy_q;
    assign RESULT_BCD  = result_bcd_q;
    assign RESULT_SIGN = sign_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_calc_accumulator_engine.sv
// Self-checking bench for calc_accumulator_engine: vector table plus multi-cycle corner sequences.
// Expected results are queued when a command is driven and compared when CMD_DONE appears.
module tb_calc_accumulator_engine;
    localparam int DW = 10;
    localparam int DG = 5;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           CMD_CLEAR, CMD_COMPUTE, CMD_OPERATION;
    logic [DW-1:0]  OPERAND;
    logic           CMD_DONE, BUSY, RESULT_SIGN, OVERFLOW;
    logic [4*DG-1:0] RESULT_BCD;

    calc_accumulator_engine dut (
        .CLK(CLK), .RESET(RESET), .CMD_CLEAR(CMD_CLEAR), .CMD_COMPUTE(CMD_COMPUTE),
        .CMD_OPERATION(CMD_OPERATION), .OPERAND(OPERAND), .CMD_DONE(CMD_DONE), .BUSY(BUSY),
        .RESULT_BCD(RESULT_BCD), .RESULT_SIGN(RESULT_SIGN), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          clr;
        logic          cmp;
        logic          op;
        logic [DW-1:0] opnd;
        logic [19:0]   bcd;
        logic          sign;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] disp(input logic [19:0] b);
        logic [19:0] r;
        r = b;
`ifdef CALC_LEADING_ZERO_BLANK_EN
        for (int i = DG-1; i >= 1; i--) begin
            if (r[4*i +: 4] != 4'd0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard side: every CMD_DONE must match the oldest queued expectation
    always @(negedge CLK) begin
        exp_t e;
        if (CMD_DONE === 1'b1) begin
            done_seen++;
            check("busy_low_at_done", {31'd0, BUSY}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result_bcd", {12'd0, RESULT_BCD}, {12'd0, e.bcd});
                check("result_sign", {31'd0, RESULT_SIGN}, {31'd0, e.sign});
                check("overflow", {31'd0, OVERFLOW}, {31'd0, e.ovf});
            end
        end
    end

    // poke >= 0 injects a COMPUTE pulse that many cycles after the sampling edge (must be ignored)
    task automatic issue(input logic clr, input logic cmp, input logic op, input logic [DW-1:0] opnd,
                         input logic [19:0] bcd, input logic sign, input logic ovf, input int poke);
        int   n;
        logic seen;
        exp_t e;
        @(negedge CLK);
        CMD_CLEAR = clr; CMD_COMPUTE = cmp; CMD_OPERATION = op; OPERAND = opnd;
        e.bcd = disp(bcd); e.sign = sign; e.ovf = ovf;
        sb_q.push_back(e);
        @(posedge CLK); #1;
        CMD_CLEAR = 1'b0; CMD_COMPUTE = 1'b0;
        check("busy_after_sample", {31'd0, BUSY}, 32'd1);
        check("no_done_at_sample", {31'd0, CMD_DONE}, 32'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (n == poke) begin
                CMD_COMPUTE = 1'b1; CMD_OPERATION = 1'b0; OPERAND = 10'd100;
            end
            @(posedge CLK); #1;
            CMD_COMPUTE = 1'b0;
            n++;
            if (CMD_DONE === 1'b1) seen = 1'b1;
        end
        check("done_latency", n, 32'd16);
        @(posedge CLK); #1;
        check("done_one_cycle", {31'd0, CMD_DONE}, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        int d0;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 10'd0,   20'h00000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 10'd999, 20'h00999, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 10'd999, 20'h01998, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 10'd0,   20'h00000, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 10'd5,   20'h00005, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 10'd5,   20'h00000, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 10'd0,   20'h00000, 1'b0, 1'b0};

        RESET = 1'b1; CMD_CLEAR = 1'b0; CMD_COMPUTE = 1'b0; CMD_OPERATION = 1'b0; OPERAND = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_done", {31'd0, CMD_DONE}, 32'd0);
        check("reset_bcd", {12'd0, RESULT_BCD}, 32'd0);
        check("reset_sign_ovf", {30'd0, RESULT_SIGN, OVERFLOW}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 7; i++)
            issue(tbl[i].clr, tbl[i].cmp, tbl[i].op, tbl[i].opnd, tbl[i].bcd, tbl[i].sign, tbl[i].ovf, -1);

        // Saturation: 32 x 1023 = 32736 fits, the 33rd add clamps at 32767
        for (int i = 1; i <= 32; i++)
            issue(1'b0, 1'b1, 1'b0, 10'd1023, to_bcd(i * 1023), 1'b0, 1'b0, -1);
        issue(1'b0, 1'b1, 1'b0, 10'd1023, 20'h32767, 1'b0, 1'b1, -1);
        issue(1'b0, 1'b1, 1'b1, 10'd1,    20'h32766, 1'b0, 1'b0, -1);

        // CLEAR wins over simultaneous COMPUTE
        issue(1'b1, 1'b1, 1'b0, 10'd7, 20'h00000, 1'b0, 1'b0, -1);

        // COMPUTE while BUSY is dropped: one DONE, result unaffected
        d0 = done_seen;
        issue(1'b0, 1'b1, 1'b0, 10'd3, 20'h00003, 1'b0, 1'b0, 5);
        check("single_done_when_poked", done_seen - d0, 32'd1);
        repeat (20) @(posedge CLK);
        #1;
        check("poke_not_queued", done_seen - d0, 32'd1);

        // Reset during conversion aborts the command without a DONE
        d0 = done_seen;
        @(negedge CLK);
        CMD_COMPUTE = 1'b1; CMD_OPERATION = 1'b0; OPERAND = 10'd9;
        @(posedge CLK); #1;
        CMD_COMPUTE = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        check("busy_mid_conv", {31'd0, BUSY}, 32'd1);
        RESET = 1'b1;
        #1;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, CMD_DONE}, 32'd0);
        check("abort_bcd", {12'd0, RESULT_BCD}, 32'd0);
        check("abort_sign_ovf", {30'd0, RESULT_SIGN, OVERFLOW}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (30) @(posedge CLK);
        #1;
        check("no_done_after_abort", done_seen - d0, 32'd0);

        issue(1'b0, 1'b1, 1'b0, 10'd5, 20'h00005, 1'b0, 1'b0, -1);
        issue(1'b1, 1'b0, 1'b0, 10'd0, 20'h00000, 1'b0, 1'b0, -1);

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
